// File: rtl/ram_arb_pkg.sv
// Shared constants and request record for the RAM write-port arbiter.
// The request record is sized for the widest supported configuration; unused high bits are zero-padded.
package ram_arb_pkg;

    localparam int DEFAULT_DEPTH        = 32;
    localparam int DEFAULT_INDEX        = 5;
    localparam int DEFAULT_WIDTH        = 32;
    localparam int DEFAULT_NUM_WR_PORTS = 2;
    localparam int DEFAULT_NUM_REQ      = 4;

    localparam int REQ_ADDR_MAX = 16;
    localparam int REQ_DATA_MAX = 64;

    typedef struct packed {
        logic                    valid;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] data;
    } req_t;

    // Round-robin index wrap for idx in [0, 2*n).
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/addr_onehot_decode.sv
// Binary-to-one-hot RAM address decode; addresses at or beyond DEPTH produce
// an all-zero vector and raise the out-of-range flag.
module addr_onehot_decode
    import ram_arb_pkg::*;
#(
    parameter int INDEX = DEFAULT_INDEX,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic [INDEX-1:0] i_addr,
    output logic [DEPTH-1:0] o_onehot,
    output logic             o_out_of_range
);

    logic [31:0] w_addr_ext;

    assign w_addr_ext     = 32'(i_addr);
    assign o_out_of_range = (w_addr_ext >= 32'(DEPTH));

    always_comb begin
        o_onehot = '0;
        for (int d = 0; d < DEPTH; d++) begin
            o_onehot[d] = !o_out_of_range && (w_addr_ext == 32'(d));
        end
    end

endmodule

// File: rtl/ram_wr_port_arbiter.sv
// Round-robin arbiter mapping NUM_REQ write requesters onto NUM_WR_PORTS RAM
// write ports. Handshake: a request transfers in the cycle where reqValid_i and reqReady_o are both high.
module ram_wr_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int INDEX        = DEFAULT_INDEX,
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int NUM_WR_PORTS = DEFAULT_NUM_WR_PORTS,
    parameter int NUM_REQ      = DEFAULT_NUM_REQ
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                ramGated_i,
    input  logic                                ramReady_i,
    input  logic [NUM_REQ-1:0]                  reqValid_i,
    input  logic [NUM_REQ-1:0][INDEX-1:0]       reqAddr_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]       reqData_i,
    output logic [NUM_REQ-1:0]                  reqReady_o,
    output logic [NUM_WR_PORTS-1:0]             wrEn_o,
    output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]  addrWr_o,
    output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]  dataWr_o,
    output logic                                addrErr_o
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_W-1:0]                        r_rr_ptr;
    logic [RR_W-1:0]                        w_rr_next;
    logic                                   w_can_grant;
    req_t                                   w_req [NUM_REQ];
    logic [NUM_REQ-1:0]                     w_grant;
    logic [NUM_WR_PORTS-1:0]                w_port_valid;
    logic [NUM_WR_PORTS-1:0]                w_port_oor;
    logic [NUM_WR_PORTS-1:0][REQ_ADDR_MAX-1:0] w_port_addr_full;
    logic [NUM_WR_PORTS-1:0][REQ_DATA_MAX-1:0] w_port_data_full;
    logic [NUM_WR_PORTS-1:0][DEPTH-1:0]     w_port_onehot;
    logic                                   w_unused_pad;

    logic [NUM_WR_PORTS-1:0]                r_wr_en;
    logic [NUM_WR_PORTS-1:0][DEPTH-1:0]     r_addr_wr;
    logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     r_data_wr;
    logic                                   r_addr_err;

    // Reset is included so no grant is offered while the block is held in reset.
    assign w_can_grant = reset_n && ramReady_i && !ramGated_i;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            w_req[r].valid = reqValid_i[r];
            w_req[r].addr  = REQ_ADDR_MAX'(reqAddr_i[r]);
            w_req[r].data  = REQ_DATA_MAX'(reqData_i[r]);
        end
    end

    // Grant selection: scan from r_rr_ptr, skipping address clashes, filling ports in order.
    always_comb begin
        int   v_cnt;
        int   v_idx;
        req_t v_req;
        logic v_clash;

        w_grant          = '0;
        w_port_valid     = '0;
        w_port_addr_full = '0;
        w_port_data_full = '0;
        w_rr_next        = r_rr_ptr;
        v_cnt            = 0;
        v_idx            = 0;
        v_req            = '0;
        v_clash          = 1'b0;

        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = rr_wrap(i + int'(r_rr_ptr), NUM_REQ);
            v_req = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == v_idx) v_req = w_req[r];
            end

            v_clash = 1'b0;
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (k < v_cnt && w_port_addr_full[k] == v_req.addr) v_clash = 1'b1;
            end

            if (w_can_grant && v_req.valid && v_cnt < NUM_WR_PORTS && !v_clash) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (r == v_idx) w_grant[r] = 1'b1;
                end
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    if (k == v_cnt) begin
                        w_port_valid[k]     = 1'b1;
                        w_port_addr_full[k] = v_req.addr;
                        w_port_data_full[k] = v_req.data;
                    end
                end
                v_cnt     = v_cnt + 1;
                w_rr_next = RR_W'(rr_wrap(v_idx + 1, NUM_REQ));
            end
        end
    end

    // High pad bits of the request record are always zero; this sink keeps them accounted for.
    assign w_unused_pad = ^{w_port_addr_full, w_port_data_full};

    for (genvar g = 0; g < NUM_WR_PORTS; g++) begin : g_dec
        addr_onehot_decode #(
            .INDEX (INDEX),
            .DEPTH (DEPTH)
        ) u_dec (
            .i_addr         (w_port_addr_full[g][INDEX-1:0]),
            .o_onehot       (w_port_onehot[g]),
            .o_out_of_range (w_port_oor[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_wr_en    <= '0;
            r_addr_wr  <= '0;
            r_data_wr  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_next;
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                // Out-of-range grants are consumed but never reach the RAM.
                r_wr_en[k]   <= w_port_valid[k] && !w_port_oor[k];
                r_addr_wr[k] <= (w_port_valid[k] && !w_port_oor[k]) ? w_port_onehot[k] : '0;
                r_data_wr[k] <= (w_port_valid[k] && !w_port_oor[k]) ? w_port_data_full[k][WIDTH-1:0] : '0;
            end
            r_addr_err <= r_addr_err || (|(w_port_valid & w_port_oor));
        end
    end

    always_comb begin
        reqReady_o = w_grant;
        wrEn_o     = r_wr_en;
        addrWr_o   = r_addr_wr;
        dataWr_o   = r_data_wr;
        addrErr_o  = r_addr_err;
    end

endmodule

// File: tb/tb_ram_wr_port_arbiter.sv
// Directed bench for ram_wr_port_arbiter: DEPTH=8 main instance plus a DEPTH=6
// instance on the same stimulus for the out-of-range address cases.
module tb_ram_wr_port_arbiter;

    localparam int W = 34;

    logic                  clk;
    logic                  reset_n;
    logic                  ramGated_i;
    logic                  ramReady_i;
    logic [3:0]            reqValid_i;
    logic [3:0][2:0]       reqAddr_i;
    logic [3:0][7:0]       reqData_i;

    logic [3:0]            ready_a, ready_b;
    logic [1:0]            wren_a, wren_b;
    logic [1:0][7:0]       addr_a;
    logic [1:0][5:0]       addr_b;
    logic [1:0][7:0]       data_a, data_b;
    logic                  err_a, err_b;

    logic [W-1:0]          exp_q[$];
    int                    n_checks;
    int                    n_fail;

    ram_wr_port_arbiter #(
        .DEPTH(8), .INDEX(3), .WIDTH(8), .NUM_WR_PORTS(2), .NUM_REQ(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ramGated_i(ramGated_i), .ramReady_i(ramReady_i),
        .reqValid_i(reqValid_i), .reqAddr_i(reqAddr_i), .reqData_i(reqData_i),
        .reqReady_o(ready_a), .wrEn_o(wren_a), .addrWr_o(addr_a), .dataWr_o(data_a),
        .addrErr_o(err_a)
    );

    ram_wr_port_arbiter #(
        .DEPTH(6), .INDEX(3), .WIDTH(8), .NUM_WR_PORTS(2), .NUM_REQ(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .ramGated_i(ramGated_i), .ramReady_i(ramReady_i),
        .reqValid_i(reqValid_i), .reqAddr_i(reqAddr_i), .reqData_i(reqData_i),
        .reqReady_o(ready_b), .wrEn_o(wren_b), .addrWr_o(addr_b), .dataWr_o(data_b),
        .addrErr_o(err_b)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [1:0] en, input int a0, input logic [7:0] d0,
                                              input int a1, input logic [7:0] d1);
        logic [7:0] oh0;
        logic [7:0] oh1;
        oh0 = en[0] ? (8'h01 << a0) : 8'h00;
        oh1 = en[1] ? (8'h01 << a1) : 8'h00;
        return {en, oh1, oh0, (en[1] ? d1 : 8'h00), (en[0] ? d0 : 8'h00)};
    endfunction

    function automatic logic [W-1:0] obs_word();
        return {wren_a, addr_a[1], addr_a[0],
                (wren_a[1] ? data_a[1] : 8'h00), (wren_a[0] ? data_a[0] : 8'h00)};
    endfunction

    // Driver tasks
    task automatic set_req(input int r, input bit v, input int a, input int d);
        reqValid_i[r] = v;
        reqAddr_i[r]  = 3'(a);
        reqData_i[r]  = 8'(d);
    endtask

    task automatic clear_reqs();
        reqValid_i = '0;
        reqAddr_i  = '0;
        reqData_i  = '0;
    endtask

    // Inputs are already driven; check grant mid-cycle, then the registered write after the edge.
    task automatic step(input string tag, input logic [3:0] exp_rdy, input logic [W-1:0] exp_out);
        @(negedge clk);
        check({tag, "_ready"}, 64'(ready_a), 64'(exp_rdy));
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        check({tag, "_write"}, 64'(obs_word()), 64'(exp_q.pop_front()));
    endtask

    // Leaves the bench at posedge+1 with reset just released.
    task automatic do_reset(input string tag);
        clear_reqs();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_wren"}, 64'(wren_a), 64'(0));
        check({tag, "_rst_addr"}, 64'(addr_a), 64'(0));
        check({tag, "_rst_data"}, 64'(data_a), 64'(0));
        check({tag, "_rst_err"},  64'({err_a, err_b}), 64'(0));
        check({tag, "_rst_rr"},   64'(dut.r_rr_ptr), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b1;
        ramGated_i = 1'b0;
        ramReady_i = 1'b1;
        clear_reqs();

        do_reset("init");

        // Single request, first edge after reset.
        set_req(0, 1, 3, 'hA5);
        step("s1", 4'b0001, exp_word(2'b01, 3, 8'hA5, 0, 8'h00));
        check("s1_rr", 64'(dut.r_rr_ptr), 64'(1));
        clear_reqs();
        step("s1_idle", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));

        // Gated / not ready, then resume from held pointer (1).
        ramGated_i = 1'b1;
        for (int r = 0; r < 4; r++) set_req(r, 1, r, 'h30 + r);
        step("gate1", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));
        step("gate2", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));
        check("gate_rr", 64'(dut.r_rr_ptr), 64'(1));
        ramGated_i = 1'b0;
        ramReady_i = 1'b0;
        step("notrdy", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));
        ramReady_i = 1'b1;
        step("resume", 4'b0110, exp_word(2'b11, 1, 8'h31, 2, 8'h32));
        check("resume_rr", 64'(dut.r_rr_ptr), 64'(3));
        set_req(1, 0, 0, 0);
        set_req(2, 0, 0, 0);
        step("wrap", 4'b1001, exp_word(2'b11, 3, 8'h33, 0, 8'h30));
        check("wrap_rr", 64'(dut.r_rr_ptr), 64'(1));
        clear_reqs();
        step("wrap_idle", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));

        // All four valid, distinct addresses.
        do_reset("all");
        for (int r = 0; r < 4; r++) set_req(r, 1, r, 'h10 + r);
        step("all1", 4'b0011, exp_word(2'b11, 0, 8'h10, 1, 8'h11));
        set_req(0, 1, 4, 'h20);
        set_req(1, 1, 5, 'h21);
        step("all2", 4'b1100, exp_word(2'b11, 2, 8'h12, 3, 8'h13));
        check("all_rr", 64'(dut.r_rr_ptr), 64'(0));
        clear_reqs();

        // Same-cycle address clash.
        do_reset("clash");
        set_req(1, 1, 5, 'h51);
        set_req(2, 1, 5, 'h52);
        step("clash1", 4'b0010, exp_word(2'b01, 5, 8'h51, 0, 8'h00));
        set_req(1, 0, 0, 0);
        step("clash2", 4'b0100, exp_word(2'b01, 5, 8'h52, 0, 8'h00));
        check("clash_rr", 64'(dut.r_rr_ptr), 64'(3));
        clear_reqs();

        // Out-of-range address on the DEPTH=6 instance.
        do_reset("oor");
        set_req(0, 1, 7, 'h77);
        set_req(1, 1, 2, 'h22);
        step("oor", 4'b0011, exp_word(2'b11, 7, 8'h77, 2, 8'h22));
        check("oor_b_ready_dropped", 64'(wren_b), 64'(2'b10));
        check("oor_b_addr0", 64'(addr_b[0]), 64'(0));
        check("oor_b_addr1", 64'(addr_b[1]), 64'(6'h04));
        check("oor_b_data1", 64'(data_b[1]), 64'(8'h22));
        check("oor_err", 64'({err_a, err_b}), 64'(2'b01));
        clear_reqs();
        step("oor_idle", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));
        check("oor_err_sticky", 64'(err_b), 64'(1));
        check("oor_b_idle", 64'(wren_b), 64'(0));
        do_reset("oor_clr");

        // Reset asserted while a grant is being offered: no strobe follows.
        set_req(0, 1, 6, 'h66);
        @(negedge clk);
        check("rst_a_ready_pre", 64'(ready_a), 64'(4'b0001));
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_a_ready_in_reset", 64'(ready_a), 64'(0));
        @(posedge clk);
        #1;
        check("rst_a_no_pulse", 64'(wren_a), 64'(0));
        clear_reqs();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_a_after", 64'({wren_a, addr_a}), 64'(0));

        // Reset asserted while a write strobe is visible: cleared without a clock edge.
        @(posedge clk);
        #1;
        set_req(0, 1, 2, 'h22);
        step("rst_b", 4'b0001, exp_word(2'b01, 2, 8'h22, 0, 8'h00));
        clear_reqs();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_b_async_wren", 64'(wren_a), 64'(0));
        check("rst_b_async_addr", 64'(addr_a), 64'(0));
        check("rst_b_async_data", 64'(data_a), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("rst_b_idle", 4'b0000, exp_word(2'b00, 0, 8'h00, 0, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
